// File: rtl/iie_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : iie_timing_generator
// Brief    : Apple IIe master timing. Divides clk_14M into CPU phases, the
//            stretched end-of-line cycle, colour reference and scan counters.
// Revision : 1.0 - initial release
// ============================================================================
module iie_timing_generator #(
    parameter int CYCLE_LEN     = 14,
    parameter int STRETCH       = 2,
    parameter int Q3_HIGH       = 4,
    parameter int LINE_CYCLES   = 65,
    parameter int HBLANK_CYCLES = 25,
    parameter int VISIBLE_LINES = 192,
    parameter int LINES_NTSC    = 262,
    parameter int LINES_PAL     = 312
) (
    input  logic       clk_14M,
    input  logic       reset,
    input  logic       pal,
    output logic       phi0,
    output logic       q3,
    output logic       cpu_ce,
    output logic       phi0_rise,
    output logic       long_cycle,
    output logic       color_ref,
    output logic [6:0] h_count,
    output logic [8:0] v_count,
    output logic       hblank,
    output logic       vblank,
    output logic       frame_start
);

    localparam int HALF     = CYCLE_LEN / 2;
    localparam int LONG_LEN = CYCLE_LEN + STRETCH;
    localparam int TW       = (LONG_LEN > 1) ? $clog2(LONG_LEN) : 1;

    localparam logic [TW-1:0] C_T_HALF      = TW'(HALF);
    localparam logic [TW-1:0] C_T_LAST_NORM = TW'(CYCLE_LEN - 1);
    localparam logic [TW-1:0] C_T_LAST_LONG = TW'(LONG_LEN - 1);
    localparam logic [TW-1:0] C_Q3_HIGH     = TW'(Q3_HIGH);
    localparam logic [6:0]    C_H_LAST      = 7'(LINE_CYCLES - 1);
    localparam logic [6:0]    C_H_BLANK     = 7'(HBLANK_CYCLES);
    localparam logic [8:0]    C_V_LAST_NTSC = 9'(LINES_NTSC - 1);
    localparam logic [8:0]    C_V_LAST_PAL  = 9'(LINES_PAL - 1);
    localparam logic [8:0]    C_V_VISIBLE   = 9'(VISIBLE_LINES);

    logic [TW-1:0] t_q, t_d;
    logic [6:0]    h_q, h_d;
    logic [8:0]    v_q, v_d;
    logic [1:0]    c4_q, c4_d;
    logic          pal_q, pal_d;

    logic          w_long;
    logic [TW-1:0] w_t_last;
    logic          w_cpu_ce;
    logic          w_h_wrap;
    logic [8:0]    w_v_last;
    logic          w_v_wrap;
    logic          w_phi0;
    logic [TW-1:0] w_offset;

    // The last CPU cycle of every line carries the stretch in its PHI0-high half.
    assign w_long   = (h_q == C_H_LAST);
    assign w_t_last = w_long ? C_T_LAST_LONG : C_T_LAST_NORM;
    assign w_cpu_ce = (t_q == w_t_last);
    assign w_h_wrap = w_cpu_ce && w_long;
    assign w_v_last = pal_q ? C_V_LAST_PAL : C_V_LAST_NTSC;
    assign w_v_wrap = w_h_wrap && (v_q == w_v_last);

    always_comb begin
        t_d   = w_cpu_ce ? '0 : t_q + TW'(1);
        h_d   = h_q;
        v_d   = v_q;
        pal_d = pal_q;
        c4_d  = c4_q + 2'd1;
        if (w_cpu_ce) begin
            h_d = w_h_wrap ? 7'd0 : h_q + 7'd1;
        end
        if (w_h_wrap) begin
            v_d = (v_q == w_v_last) ? 9'd0 : v_q + 9'd1;
        end
        // Mode only changes on a frame boundary so v_count never overruns.
        if (w_v_wrap) begin
            pal_d = pal;
        end
    end

    always_ff @(posedge clk_14M) begin
        if (reset) begin
            t_q   <= '0;
            h_q   <= 7'd0;
            v_q   <= 9'd0;
            c4_q  <= 2'd0;
            pal_q <= pal;
        end else begin
            t_q   <= t_d;
            h_q   <= h_d;
            v_q   <= v_d;
            c4_q  <= c4_d;
            pal_q <= pal_d;
        end
    end

    assign w_phi0   = (t_q >= C_T_HALF);
    assign w_offset = w_phi0 ? (t_q - C_T_HALF) : t_q;

    assign phi0        = w_phi0;
    assign q3          = (w_offset < C_Q3_HIGH);
    assign cpu_ce      = w_cpu_ce;
    assign phi0_rise   = (t_q == C_T_HALF);
    assign long_cycle  = w_long;
    assign color_ref   = c4_q[1];
    assign h_count     = h_q;
    assign v_count     = v_q;
    assign hblank      = (h_q < C_H_BLANK);
    assign vblank      = (v_q >= C_V_VISIBLE);
    assign frame_start = (t_q == '0) && (h_q == 7'd0) && (v_q == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_iie_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_iie_timing_generator
// Brief    : Directed self-checking bench; frame heights shortened to keep
//            runs brief while line timing keeps the default 912 ticks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iie_timing_generator;

    localparam int VIS  = 4;
    localparam int NTSC = 6;
    localparam int PALN = 8;

    logic       clk_14M = 1'b0;
    logic       reset   = 1'b1;
    logic       pal     = 1'b0;
    logic       phi0, q3, cpu_ce, phi0_rise, long_cycle, color_ref;
    logic [6:0] h_count;
    logic [8:0] v_count;
    logic       hblank, vblank, frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    iie_timing_generator #(
        .CYCLE_LEN(14), .STRETCH(2), .Q3_HIGH(4), .LINE_CYCLES(65),
        .HBLANK_CYCLES(25), .VISIBLE_LINES(VIS), .LINES_NTSC(NTSC), .LINES_PAL(PALN)
    ) u_dut (
        .clk_14M(clk_14M), .reset(reset), .pal(pal),
        .phi0(phi0), .q3(q3), .cpu_ce(cpu_ce), .phi0_rise(phi0_rise),
        .long_cycle(long_cycle), .color_ref(color_ref),
        .h_count(h_count), .v_count(v_count),
        .hblank(hblank), .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk_14M = ~clk_14M;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_14M);
        #1;
    endtask

    // Step until the given h/v position is observed; returns steps taken.
    task automatic wait_hv(input int h, input int v, input int budget, output int n);
        n = 0;
        while (!(h_count == 7'(h) && v_count == 9'(v)) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("wait_hv_timeout", 0, 1);
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_phi0"}, phi0, 0);
        chk({pfx, "_q3"}, q3, 1);
        chk({pfx, "_cpu_ce"}, cpu_ce, 0);
        chk({pfx, "_phi0_rise"}, phi0_rise, 0);
        chk({pfx, "_long"}, long_cycle, 0);
        chk({pfx, "_color"}, color_ref, 0);
        chk({pfx, "_hblank"}, hblank, 1);
        chk({pfx, "_vblank"}, vblank, 0);
        chk({pfx, "_fstart"}, frame_start, 1);
        chk({pfx, "_h"}, int'(h_count), 0);
        chk({pfx, "_v"}, int'(v_count), 0);
    endtask

    initial begin
        logic [13:0] exp_phi0, exp_q3, exp_ce, exp_rise;
        logic [7:0]  exp_col;
        int n, ones, hi, ce_at, vmax, cap_v, cap_h;
        logic prev_hb, prev_vb;

        exp_phi0 = 14'b11111110000000;
        exp_q3   = 14'b00011110001111;
        exp_ce   = 14'b10000000000000;
        exp_rise = 14'b00000010000000;
        exp_col  = 8'b11001100;

        // Reset held
        repeat (3) step();
        chk_reset_state("rst");

        // Release: one full normal cycle, ticks 0..13
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("rel_phi0_t%0d", k), phi0, int'(exp_phi0[k]));
            chk($sformatf("rel_q3_t%0d", k), q3, int'(exp_q3[k]));
            chk($sformatf("rel_ce_t%0d", k), cpu_ce, int'(exp_ce[k]));
            chk($sformatf("rel_rise_t%0d", k), phi0_rise, int'(exp_rise[k]));
            step();
        end
        chk("rel_h_after_cycle", int'(h_count), 1);

        // Long cycle at h_count=64
        wait_hv(64, 0, 2000, n);
        chk("to_h64_ticks", n, 63 * 14);
        ones = 0; hi = 0; ce_at = -1;
        for (int i = 0; i < 16; i++) begin
            if (long_cycle) ones++;
            if (phi0) hi++;
            if (cpu_ce) ce_at = i;
            step();
        end
        chk("long_cycle_ticks", ones, 16);
        chk("long_phi0_high", hi, 9);
        chk("long_ce_tick", ce_at, 15);
        chk("long_h_wrap", int'(h_count), 0);
        chk("long_v_inc", int'(v_count), 1);

        // Full line length
        step();
        wait_hv(0, 2, 2000, n);
        chk("line_ticks", n + 1, 912);

        // Colour reference: 1824 edges since release, so c4 starts at 0
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("color_t%0d", i), color_ref, int'(exp_col[i]));
            step();
        end
        for (int l = 0; l < 9; l++) begin
            n = 0;
            while (h_count != 7'd1 && n < 2000) begin step(); n++; end
            while (h_count != 7'd0 && n < 2000) begin step(); n++; end
            if (n >= 2000) chk("color_line_timeout", 0, 1);
            chk($sformatf("color_line%0d", l + 1), color_ref, 0);
        end

        // Frame spacing (NTSC), vblank rise and hblank fall positions
        n = 0;
        while (!frame_start && n < 10000) begin step(); n++; end
        if (n >= 10000) chk("fs_timeout", 0, 1);
        n = 0; cap_v = -1; cap_h = -1;
        prev_hb = hblank; prev_vb = vblank;
        do begin
            step(); n++;
            if (vblank && !prev_vb && cap_v < 0) cap_v = int'(v_count);
            if (!hblank && prev_hb && cap_h < 0) cap_h = int'(h_count);
            prev_hb = hblank; prev_vb = vblank;
        end while (!frame_start && n < 10000);
        chk("ntsc_frame_ticks", n, NTSC * 912);
        chk("vblank_rise_v", cap_v, VIS);
        chk("hblank_fall_h", cap_h, 25);

        // Mode switch mid-frame: current frame stays NTSC, next is PAL
        wait_hv(0, 2, 4000, n);
        pal = 1'b1;
        n = 0; vmax = 0;
        while (!frame_start && n < 10000) begin
            if (int'(v_count) > vmax) vmax = int'(v_count);
            step(); n++;
        end
        chk("switch_cur_vmax", vmax, NTSC - 1);
        n = 0; vmax = 0;
        do begin
            if (int'(v_count) > vmax) vmax = int'(v_count);
            step(); n++;
        end while (!frame_start && n < 10000);
        chk("pal_frame_ticks", n, PALN * 912);
        chk("pal_vmax", vmax, PALN - 1);

        // Mid-operation reset at t=9, h=40, v=3
        wait_hv(40, 3, 8000, n);
        repeat (9) step();
        chk("pre_rst_phi0", phi0, 1);
        reset = 1'b1;
        step();
        chk_reset_state("midrst");
        reset = 1'b0;
        n = 0;
        while (!cpu_ce && n < 40) begin step(); n++; end
        chk("midrst_ce_latency", n, 13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
